pipe_hazard_ctrl: RTL and testbench

- Central stall/flush sequencer for the 5-stage in-order core (IF, ID, EX, MEM, WB).
- Drives the stall/flush pair of each of the four enable-DFF pipeline registers: 0 = if_id, 1 = id_ex, 2 = ex_mem, 3 = mem_wb.
- Also drives PC hold and redirect, sequences the multi-cycle MDU handshake in EX, and discards stale fetch responses after a redirect.
- Sits beside the datapath with no data-path logic of its own.

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_mdu_seq.sv | 75 +++++++
 rtl/pipe_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared core definitions for the hazard sequencer: pipeline register
// indices, MDU and fetch-drop state encodings, and width defaults.
package pipe_hazard_ctrl_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int REG_AW_DEF = 5;
  localparam int CNT_W_DEF  = 32;

  // Bit positions in the stall/flush vectors.
  localparam int IF_ID  = 0;
  localparam int ID_EX  = 1;
  localparam int EX_MEM = 2;
  localparam int MEM_WB = 3;

  localparam logic [1:0] MDU_IDLE = 2'd0;
  localparam logic [1:0] MDU_BUSY = 2'd1;
  localparam logic [1:0] MDU_DONE = 2'd2;

  localparam logic [0:0] F_NORMAL = 1'b0;
  localparam logic [0:0] F_DROP   = 1'b1;

endpackage

// File: rtl/pipe_hazard_ctrl_mdu_seq.sv
// MDU handshake sequencer (IDLE -> BUSY -> DONE -> IDLE).
// Ports:
//   clk, rst        core clock, async active-high reset
//   ex_mdu_req_i    EX holds a mul/div instruction
//   mdu_done_i      MDU result valid pulse
//   trap_req_i      trap taken; aborts any in-flight op
//   dmem_wait_i     MEM stalled; launch is deferred
//   mdu_start_o     launch pulse
//   mdu_kill_o      abort pulse
//   mdu_stall_o     EX must hold for the MDU
module pipe_mdu_seq
  import pipe_hazard_ctrl_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic ex_mdu_req_i,
  input  logic mdu_done_i,
  input  logic trap_req_i,
  input  logic dmem_wait_i,
  output logic mdu_start_o,
  output logic mdu_kill_o,
  output logic mdu_stall_o
);

  logic [1:0] state_q, state_d;
  logic       start, kill;

  // NOTE: every signal written here gets a default first, so no path leaves
  // it unassigned and no latch is inferred.
  always_comb begin
    state_d     = state_q;
    start       = 1'b0;
    kill        = 1'b0;
    mdu_stall_o = 1'b0;
    case (state_q)
      MDU_IDLE: begin
        if (ex_mdu_req_i) begin
          mdu_stall_o = 1'b1;
          if (!trap_req_i && !dmem_wait_i) begin
            start   = 1'b1;
            state_d = MDU_BUSY;
          end
        end
      end
      MDU_BUSY: begin
        mdu_stall_o = 1'b1;
        // A done pulse coinciding with a trap is dropped: the kill wins.
        if (trap_req_i) begin
          kill    = 1'b1;
          state_d = MDU_IDLE;
        end else if (mdu_done_i) begin
          state_d = MDU_DONE;
        end
      end
      MDU_DONE: begin
        // Result is being consumed; no stall and no relaunch this cycle.
        kill    = trap_req_i;
        state_d = MDU_IDLE;
      end
      default: state_d = MDU_IDLE;
    endcase
  end

  // Launch/kill depend on live inputs, so they are gated while in reset.
  assign mdu_start_o = start & ~rst;
  assign mdu_kill_o  = kill & ~rst;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= MDU_IDLE;
    else     state_q <= state_d;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage in-order core.
// Ports:
//   clk, rst                       core clock, async active-high reset
//   id_rs1/rs2, id_rs*_ren         ID source indices and read enables
//   ex_rd, ex_mem_read             EX destination and load flag
//   ex_branch_taken/target         EX redirect request
//   ex_mdu_req, mdu_done           MDU request / result pulse
//   mdu_start, mdu_kill            MDU launch / abort
//   imem_wait, dmem_wait           fetch / MEM access pending
//   trap_req, trap_target          trap at MEM/WB boundary
//   stall[3:0], flush[3:0]         per-pipeline-register hold / zero
//   pc_stall, pc_redirect, redirect_pc   PC control
//   stall_cnt                      cycles with pc_stall asserted
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int REG_AW = REG_AW_DEF,
  parameter int CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_rs1_ren,
  input  logic              id_rs2_ren,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_mem_read,
  input  logic              ex_branch_taken,
  input  logic [XLEN-1:0]   ex_branch_target,
  input  logic              ex_mdu_req,
  input  logic              mdu_done,
  output logic              mdu_start,
  output logic              mdu_kill,
  input  logic              imem_wait,
  input  logic              dmem_wait,
  input  logic              trap_req,
  input  logic [XLEN-1:0]   trap_target,
  output logic [3:0]        stall,
  output logic [3:0]        flush,
  output logic              pc_stall,
  output logic              pc_redirect,
  output logic [XLEN-1:0]   redirect_pc,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic             mdu_stall;
  logic             load_use;
  logic [0:0]       f_state_q, f_state_d;
  logic [CNT_W-1:0] stall_cnt_q;

  pipe_mdu_seq u_mdu_seq (
    .clk         (clk),
    .rst         (rst),
    .ex_mdu_req_i(ex_mdu_req),
    .mdu_done_i  (mdu_done),
    .trap_req_i  (trap_req),
    .dmem_wait_i (dmem_wait),
    .mdu_start_o (mdu_start),
    .mdu_kill_o  (mdu_kill),
    .mdu_stall_o (mdu_stall)
  );

  // x0 is never a real dependency.
  assign load_use = ex_mem_read && (ex_rd != '0) &&
                    ((id_rs1_ren && (id_rs1 == ex_rd)) ||
                     (id_rs2_ren && (id_rs2 == ex_rd)));

  always_comb begin
    stall       = 4'b0000;
    flush       = 4'b0000;
    pc_stall    = 1'b0;
    pc_redirect = 1'b0;
    redirect_pc = '0;
    if (trap_req) begin
      flush       = 4'hF;
      pc_redirect = 1'b1;
      redirect_pc = trap_target;
    end else if (dmem_wait) begin
      // A taken branch in EX is frozen with it and redirects afterwards.
      pc_stall       = 1'b1;
      stall          = 4'b0111;
      flush[MEM_WB]  = 1'b1;
    end else if (mdu_stall) begin
      pc_stall       = 1'b1;
      stall          = 4'b0011;
      flush[EX_MEM]  = 1'b1;
    end else if (ex_branch_taken) begin
      flush[IF_ID]   = 1'b1;
      flush[ID_EX]   = 1'b1;
      pc_redirect    = 1'b1;
      redirect_pc    = ex_branch_target;
    end else if (load_use) begin
      pc_stall       = 1'b1;
      stall[IF_ID]   = 1'b1;
      flush[ID_EX]   = 1'b1;
    end
    // Fetch handling is layered on top of whichever rule fired above.
    if (imem_wait && !pc_redirect) begin
      pc_stall     = 1'b1;
      flush[IF_ID] = 1'b1;
    end
    // Any response still owed to a pre-redirect fetch is stale.
    if (f_state_q == F_DROP) flush[IF_ID] = 1'b1;
    if (rst) begin
      stall       = 4'b0000;
      flush       = 4'hF;
      pc_stall    = 1'b1;
      pc_redirect = 1'b0;
      redirect_pc = '0;
    end
  end

  always_comb begin
    f_state_d = f_state_q;
    if (f_state_q == F_NORMAL) begin
      if (pc_redirect && imem_wait) f_state_d = F_DROP;
    end else if (!imem_wait && !pc_redirect) begin
      // The response arriving now is the stale one; it is flushed above.
      f_state_d = F_NORMAL;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_state_q   <= F_NORMAL;
      stall_cnt_q <= '0;
    end else begin
      f_state_q <= f_state_d;
      if (pc_stall) stall_cnt_q <= stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: the stimulus process drives one
// vector per cycle just after the rising edge and queues the hand-computed
// response; the monitor pops and compares on every falling edge.
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rd;
  logic        id_rs1_ren, id_rs2_ren, ex_mem_read, ex_branch_taken;
  logic [63:0] ex_branch_target, trap_target, redirect_pc;
  logic        ex_mdu_req, mdu_done, mdu_start, mdu_kill;
  logic        imem_wait, dmem_wait, trap_req;
  logic [3:0]  stall, flush;
  logic        pc_stall, pc_redirect;
  logic [31:0] stall_cnt;

  localparam logic [63:0] BR_T  = 64'h0000_0000_8000_0040;
  localparam logic [63:0] TR_T  = 64'h0000_0000_0000_0100;
  localparam logic [63:0] BR_T2 = 64'h0000_0000_0000_1234;

  typedef struct {
    int          tag;
    logic [3:0]  stall;
    logic [3:0]  flush;
    logic        pc_stall;
    logic        pc_redirect;
    logic [63:0] rpc;
    logic        start;
    logic        kill;
    logic [31:0] cnt;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   tag_n    = 0;

  pipe_hazard_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .id_rs1          (id_rs1),
    .id_rs2          (id_rs2),
    .id_rs1_ren      (id_rs1_ren),
    .id_rs2_ren      (id_rs2_ren),
    .ex_rd           (ex_rd),
    .ex_mem_read     (ex_mem_read),
    .ex_branch_taken (ex_branch_taken),
    .ex_branch_target(ex_branch_target),
    .ex_mdu_req      (ex_mdu_req),
    .mdu_done        (mdu_done),
    .mdu_start       (mdu_start),
    .mdu_kill        (mdu_kill),
    .imem_wait       (imem_wait),
    .dmem_wait       (dmem_wait),
    .trap_req        (trap_req),
    .trap_target     (trap_target),
    .stall           (stall),
    .flush           (flush),
    .pc_stall        (pc_stall),
    .pc_redirect     (pc_redirect),
    .redirect_pc     (redirect_pc),
    .stall_cnt       (stall_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input int tag, input string nm,
                       input logic [63:0] act, input logic [63:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL vec%0d %s: got %0h expected %0h", tag, nm, act, expv);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one entry is consumed per
  // falling edge whenever the stimulus has queued one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check(e.tag, "stall",       {60'd0, stall},       {60'd0, e.stall});
        check(e.tag, "flush",       {60'd0, flush},       {60'd0, e.flush});
        check(e.tag, "pc_stall",    {63'd0, pc_stall},    {63'd0, e.pc_stall});
        check(e.tag, "pc_redirect", {63'd0, pc_redirect}, {63'd0, e.pc_redirect});
        check(e.tag, "redirect_pc", redirect_pc,          e.rpc);
        check(e.tag, "mdu_start",   {63'd0, mdu_start},   {63'd0, e.start});
        check(e.tag, "mdu_kill",    {63'd0, mdu_kill},    {63'd0, e.kill});
        check(e.tag, "stall_cnt",   {32'd0, stall_cnt},   {32'd0, e.cnt});
      end
    end
  end

  task automatic push(input logic [3:0] s, input logic [3:0] f,
                      input logic ps, input logic pr, input logic [63:0] rpc,
                      input logic st, input logic k, input logic [31:0] c);
    exp_t e;
    e.tag = tag_n; e.stall = s; e.flush = f; e.pc_stall = ps;
    e.pc_redirect = pr; e.rpc = rpc; e.start = st; e.kill = k; e.cnt = c;
    q.push_back(e);
    tag_n++;
  endtask

  // Advance one cycle and return all functional inputs to their quiet value.
  task automatic cyc();
    @(posedge clk);
    #1;
    id_rs1 = '0; id_rs2 = '0; ex_rd = '0;
    id_rs1_ren = 1'b0; id_rs2_ren = 1'b0; ex_mem_read = 1'b0;
    ex_branch_taken = 1'b0; ex_branch_target = '0;
    ex_mdu_req = 1'b0; mdu_done = 1'b0;
    imem_wait = 1'b0; dmem_wait = 1'b0;
    trap_req = 1'b0; trap_target = '0;
  endtask

  initial begin
    rst = 1'b1;
    cyc();
    // Reset: outputs forced even with requests present.
    ex_branch_taken = 1'b1; ex_branch_target = BR_T; ex_mdu_req = 1'b1;
    push(4'b0000, 4'hF, 1, 0, 64'd0, 0, 0, 0);
    cyc(); rst = 1'b0;
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 0);

    // dmem_wait holding a taken branch for 4 cycles, redirect on the 5th.
    for (int i = 0; i < 4; i++) begin
      cyc(); dmem_wait = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = BR_T;
      push(4'b0111, 4'b1000, 1, 0, 64'd0, 0, 0, i);
    end
    cyc(); ex_branch_taken = 1'b1; ex_branch_target = BR_T;
    push(4'b0000, 4'b0011, 0, 1, BR_T, 0, 0, 4);
    // Asynchronous reset between edges clears the counter at once.
    cyc(); rst = 1'b1;
    push(4'b0000, 4'hF, 1, 0, 64'd0, 0, 0, 0);
    cyc(); rst = 1'b0;
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 0);

    // Load-use on rs1, then x0 destination, then rs2 with/without enable.
    cyc(); ex_mem_read = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_rs1_ren = 1'b1;
    push(4'b0001, 4'b0010, 1, 0, 64'd0, 0, 0, 0);
    cyc(); ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_rs1_ren = 1'b1;
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 1);
    cyc(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7;
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 1);
    cyc(); ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_rs2_ren = 1'b1;
    push(4'b0001, 4'b0010, 1, 0, 64'd0, 0, 0, 1);
    cyc();
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 2);

    // Plain taken branch.
    cyc(); ex_branch_taken = 1'b1; ex_branch_target = BR_T;
    push(4'b0000, 4'b0011, 0, 1, BR_T, 0, 0, 2);

    // MDU: start, 6 BUSY cycles (done in the 6th), DONE without restart.
    cyc(); ex_mdu_req = 1'b1;
    push(4'b0011, 4'b0100, 1, 0, 64'd0, 1, 0, 2);
    for (int i = 1; i <= 6; i++) begin
      cyc(); ex_mdu_req = 1'b1; mdu_done = (i == 6);
      push(4'b0011, 4'b0100, 1, 0, 64'd0, 0, 0, 32'(2 + i));
    end
    cyc(); ex_mdu_req = 1'b1;
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 9);
    cyc();
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 9);

    // Trap in the 3rd BUSY cycle kills the op.
    cyc(); ex_mdu_req = 1'b1;
    push(4'b0011, 4'b0100, 1, 0, 64'd0, 1, 0, 9);
    for (int i = 1; i <= 2; i++) begin
      cyc(); ex_mdu_req = 1'b1;
      push(4'b0011, 4'b0100, 1, 0, 64'd0, 0, 0, 32'(9 + i));
    end
    cyc(); ex_mdu_req = 1'b1; trap_req = 1'b1; trap_target = TR_T;
    push(4'b0000, 4'hF, 0, 1, TR_T, 0, 1, 12);
    cyc(); mdu_done = 1'b1;
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 12);
    // Back in IDLE: a new request launches straight away.
    cyc(); ex_mdu_req = 1'b1;
    push(4'b0011, 4'b0100, 1, 0, 64'd0, 1, 0, 12);
    cyc(); ex_mdu_req = 1'b1; trap_req = 1'b1; trap_target = TR_T;
    push(4'b0000, 4'hF, 0, 1, TR_T, 0, 1, 13);
    cyc();
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 13);

    // Redirect during fetch wait; imem_wait falls 3 cycles later.
    cyc(); imem_wait = 1'b1; ex_branch_taken = 1'b1; ex_branch_target = BR_T2;
    push(4'b0000, 4'b0011, 0, 1, BR_T2, 0, 0, 13);
    cyc(); imem_wait = 1'b1;
    push(4'b0000, 4'b0001, 1, 0, 64'd0, 0, 0, 13);
    cyc(); imem_wait = 1'b1;
    push(4'b0000, 4'b0001, 1, 0, 64'd0, 0, 0, 14);
    cyc();
    push(4'b0000, 4'b0001, 0, 0, 64'd0, 0, 0, 15);
    cyc();
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 15);
    // Plain fetch wait in NORMAL.
    cyc(); imem_wait = 1'b1;
    push(4'b0000, 4'b0001, 1, 0, 64'd0, 0, 0, 15);
    // Trap outranks dmem_wait.
    cyc(); dmem_wait = 1'b1; trap_req = 1'b1; trap_target = TR_T;
    push(4'b0000, 4'hF, 0, 1, TR_T, 0, 0, 16);
    cyc();
    push(4'b0000, 4'b0000, 0, 0, 64'd0, 0, 0, 16);

    for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
